traffic_checker: RTL and testbench

Receive-side companion to the traffic generator: consumes the 8-bit pseudo-random word stream over a valid/ready handshake and checks it against a locally regenerated LFSR sequence. Self-synchronises on the first non-zero word, counts accepted words and mismatches, and declares loss of lock after a run of consecutive errors. Sits at the far end of the generator link, either in a loopback test harness or in a second tile; its status outputs drive board-level pins.

---
 rtl/traffic_checker_if.sv | 18 +
 rtl/traffic_checker.sv | 136 +++++++++++++
 tb/tb_traffic_checker.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/traffic_checker_if.sv
// rtl/traffic_checker_if.sv - word stream handshake between generator and checker
interface traffic_checker_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/traffic_checker.sv
// rtl/traffic_checker.sv - LFSR stream checker with self-sync, error counting and loss-of-lock
module traffic_checker #(
    parameter int CNT_W       = 16,
    parameter int LOSS_THRESH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_throttle,
    input  logic             i_clr,
    traffic_checker_if.slave s_in,
    output logic             o_locked,
    output logic             o_err_flag,
    output logic [CNT_W-1:0] o_word_cnt,
    output logic [7:0]       o_err_cnt
);

    typedef enum logic {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    localparam logic [3:0] THRESH = 4'(LOSS_THRESH);

    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        return {cur[6:0], cur[7] ^ cur[5] ^ cur[4] ^ cur[3]};
    endfunction

    state_t           r_state;
    state_t           w_state_nxt;
    logic [7:0]       r_exp;
    logic [3:0]       r_run;
    logic             r_phase;
    logic             r_err_flag;
    logic [CNT_W-1:0] r_word_cnt;
    logic [7:0]       r_err_cnt;

    logic             w_ready;
    logic             w_fire;
    logic             w_nonzero;
    logic             w_mismatch;
    logic [3:0]       w_run_inc;
    logic             w_loss;

    // Ready is gated by reset so the generator never sees a transfer while state is being cleared.
    assign w_ready     = ~i_rst & i_en & (~i_throttle | r_phase);
    assign s_in.in_ready = w_ready;
    assign w_fire      = s_in.in_valid & w_ready;
    assign w_nonzero   = (s_in.in_data != 8'h00);
    assign w_mismatch  = (r_state == ST_LOCKED) & (s_in.in_data != r_exp);
    assign w_run_inc   = r_run + 4'd1;
    assign w_loss      = w_fire & w_mismatch & (w_run_inc == THRESH);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_HUNT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_HUNT: begin
                if (w_fire && w_nonzero) begin
                    w_state_nxt = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (w_loss) begin
                    w_state_nxt = ST_HUNT;
                end
            end
            default: w_state_nxt = ST_HUNT;
        endcase
    end

    always_comb begin
        o_locked   = (r_state == ST_LOCKED);
        o_err_flag = r_err_flag;
        o_word_cnt = r_word_cnt;
        o_err_cnt  = r_err_cnt;
    end

    // Isolated errors keep the expected sequence advancing; only a full run of misses resyncs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_exp <= 8'h00;
            r_run <= 4'd0;
        end else if (w_fire) begin
            if (r_state == ST_HUNT) begin
                if (w_nonzero) begin
                    r_exp <= lfsr_next(s_in.in_data);
                end
                r_run <= 4'd0;
            end else begin
                r_exp <= lfsr_next(r_exp);
                if (!w_mismatch || w_loss) begin
                    r_run <= 4'd0;
                end else begin
                    r_run <= w_run_inc;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_word_cnt <= '0;
            r_err_cnt  <= 8'h00;
            r_err_flag <= 1'b0;
        end else if (i_clr) begin
            r_word_cnt <= '0;
            r_err_cnt  <= 8'h00;
            r_err_flag <= 1'b0;
        end else if (w_fire) begin
            r_word_cnt <= r_word_cnt + 1'b1;
            if (w_mismatch) begin
                r_err_flag <= 1'b1;
                if (r_err_cnt != 8'hFF) begin
                    r_err_cnt <= r_err_cnt + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || !i_throttle) begin
            r_phase <= 1'b0;
        end else if (i_en) begin
            r_phase <= ~r_phase;
        end
    end

endmodule

// File: tb/tb_traffic_checker.sv
// tb/tb_traffic_checker.sv - scoreboard bench for traffic_checker with a reference model
module tb_traffic_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        throttle;
    logic        clr;
    logic        locked;
    logic        err_flag;
    logic [15:0] word_cnt;
    logic [7:0]  err_cnt;

    traffic_checker_if bus();

    traffic_checker #(.CNT_W(16), .LOSS_THRESH(4)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_en       (en),
        .i_throttle (throttle),
        .i_clr      (clr),
        .s_in       (bus),
        .o_locked   (locked),
        .o_err_flag (err_flag),
        .o_word_cnt (word_cnt),
        .o_err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct packed {
        logic        locked;
        logic        ef;
        logic [15:0] wc;
        logic [7:0]  ec;
    } exp_t;

    exp_t sb_q[$];

    bit          m_locked;
    logic [7:0]  m_exp;
    int          m_run;
    int          m_wc;
    int          m_ec;
    bit          m_ef;
    bit          tb_phase;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] lfsr_step(input logic [7:0] x);
        return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
    endfunction

    function automatic exp_t model_status();
        exp_t e;
        e.locked = m_locked;
        e.ef     = m_ef;
        e.wc     = m_wc[15:0];
        e.ec     = m_ec[7:0];
        return e;
    endfunction

    function automatic void model_reset();
        m_locked = 0; m_exp = 8'h00; m_run = 0;
        m_wc = 0; m_ec = 0; m_ef = 0;
    endfunction

    function automatic void model_clear();
        m_wc = 0; m_ec = 0; m_ef = 0;
    endfunction

    function automatic void model_beat(input logic [7:0] d, input bit c);
        bit mism = 0;
        if (m_locked) begin
            mism  = (d != m_exp);
            m_exp = lfsr_step(m_exp);
            if (mism) begin
                m_run++;
                if (m_run >= 4) begin
                    m_locked = 0;
                    m_run    = 0;
                end
            end else begin
                m_run = 0;
            end
        end else if (d != 8'h00) begin
            m_locked = 1;
            m_exp    = lfsr_step(d);
            m_run    = 0;
        end
        if (c) begin
            model_clear();
        end else begin
            m_wc = (m_wc + 1) % 65536;
            if (mism) begin
                m_ef = 1;
                if (m_ec < 255) m_ec++;
            end
        end
        sb_q.push_back(model_status());
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst || !throttle) tb_phase <= 1'b0;
        else if (en)          tb_phase <= ~tb_phase;
    end

    // Monitor: any handshake seen before an edge is checked against the scoreboard after it.
    bit prev_fire = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (prev_fire) begin
            if (sb_q.size() == 0) begin
                chk("sb_underflow", 32'd0, 32'd1);
            end else begin
                e = sb_q.pop_front();
                chk("status", {6'd0, locked, err_flag, word_cnt, err_cnt}, {6'd0, e});
            end
        end
        prev_fire = bus.in_valid & bus.in_ready;
    end

    task automatic send(input logic [7:0] d, input bit c = 1'b0);
        bit fired = 0;
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        clr          = c;
        for (int k = 0; k < 8 && !fired; k++) begin
            @(negedge clk);
            chk("ready", {31'd0, bus.in_ready}, {31'd0, en & (~throttle | tb_phase)});
            if (bus.in_ready) begin
                model_beat(d, c);
                fired = 1;
            end else if (c) begin
                model_clear();
            end
            @(posedge clk); #1;
        end
        if (!fired) chk("send_timeout", 32'd0, 32'd1);
        clr = 1'b0;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic hold_off(input int n);
        en = 1'b0;
        bus.in_valid = 1'b1;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk("ready_en0", {31'd0, bus.in_ready}, 32'd0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("hold_status", {6'd0, locked, err_flag, word_cnt, err_cnt}, {6'd0, model_status()});
        @(posedge clk); #1;
        en = 1'b1;
        bus.in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b1; throttle = 1'b0; clr = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("ready_in_reset", {31'd0, bus.in_ready}, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        chk("reset_outputs", {6'd0, locked, err_flag, word_cnt, err_cnt}, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        logic [7:0] d;
        bus.in_data = 8'h00;
        bus.in_valid = 1'b0;
        rst = 1'b1; en = 1'b0; throttle = 1'b0; clr = 1'b0;
        model_reset();
        @(posedge clk); #1;

        do_reset();
        send(8'h01); send(8'h02); send(8'h04); send(8'h08); send(8'h11);
        idle();
        chk("clean_wc", {16'd0, word_cnt}, 32'd5);
        chk("clean_locked", {31'd0, locked}, 32'd1);

        do_reset();
        send(8'h01); send(8'h02); send(8'h55); send(8'h08);
        idle();
        chk("single_err_cnt", {24'd0, err_cnt}, 32'd1);
        chk("single_err_locked", {31'd0, locked}, 32'd1);
        chk("single_err_wc", {16'd0, word_cnt}, 32'd4);

        do_reset();
        send(8'h01);
        for (int i = 0; i < 4; i++) send(8'hFF);
        idle();
        chk("loss_locked", {31'd0, locked}, 32'd0);
        send(8'h08); send(8'h11);
        idle();
        chk("relock_locked", {31'd0, locked}, 32'd1);
        chk("relock_err_cnt", {24'd0, err_cnt}, 32'd4);

        do_reset();
        send(8'h00); send(8'h00);
        idle();
        chk("zero_no_lock", {31'd0, locked}, 32'd0);
        send(8'h04);
        idle();
        chk("zero_lock", {31'd0, locked}, 32'd1);
        chk("zero_wc", {16'd0, word_cnt}, 32'd3);

        do_reset();
        throttle = 1'b1;
        t0 = cyc;
        d = 8'h01;
        for (int i = 0; i < 6; i++) begin
            send(d);
            d = lfsr_step(d);
        end
        chk("throttle_cycles", cyc - t0, 32'd12);
        idle();
        chk("throttle_wc", {16'd0, word_cnt}, 32'd6);
        throttle = 1'b0;

        do_reset();
        send(8'h01); send(8'h02); send(8'h77);
        send(8'h08, 1'b1);
        send(8'h11);
        idle();
        chk("clr_wc", {16'd0, word_cnt}, 32'd1);
        chk("clr_err_flag", {31'd0, err_flag}, 32'd0);
        chk("clr_locked", {31'd0, locked}, 32'd1);

        send(8'h23);
        do_reset();

        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 6) throttle = ~throttle;
            else if (r < 10) hold_off($urandom_range(1, 3));
            else if (r < 15) idle();
            else if (r == 99) do_reset();
            if (m_locked && $urandom_range(0, 9) < 8) d = m_exp;
            else if ($urandom_range(0, 7) == 0) d = 8'h00;
            else d = 8'($urandom);
            send(d, $urandom_range(0, 24) == 0);
        end
        idle();
        idle();
        chk("sb_empty", sb_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
